// File: rtl/wb_sram_slave.sv
// Pipelined Wishbone slave in front of a 2**AW x 32-bit single-cycle memory.
// Optional feature macro: WB_SRAM_ERR_EN (error response for addresses beyond the memory).
module wb_sram_slave #(
  parameter int AW      = 10,
  parameter int LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_stall,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_data,
  output logic        o_wb_err
);

  localparam int DEPTH = 2 ** AW;

  logic [31:0]        r_mem [DEPTH];
  logic [AW-1:0]      w_idx;
  logic               w_outOfRange;
  logic               w_readHazard;
  logic               w_accept;
  logic               w_respValid;
  logic               w_unused;
  logic               r_lastWrValid;
  logic [AW-1:0]      r_lastWrIdx;
  logic [LATENCY-1:0] r_pipeValid;
  logic [LATENCY-1:0] r_pipeErr;
  logic [31:0]        r_pipeData [LATENCY];

  assign w_idx    = i_wb_addr[AW+1:2];
  assign w_unused = &{1'b0, i_wb_addr[1:0], i_wb_addr[31:AW+2]};

`ifdef WB_SRAM_ERR_EN
  assign w_outOfRange = |i_wb_addr[31:AW+2];
`else
  assign w_outOfRange = 1'b0;
`endif

  // A read straight after a write to the same word is held off for one cycle.
  assign w_readHazard = i_wb_cyc && i_wb_stb && !i_wb_we &&
                        r_lastWrValid && (w_idx == r_lastWrIdx);
  assign o_wb_stall   = w_readHazard;
  assign w_accept     = i_wb_cyc && i_wb_stb && !w_readHazard && !i_reset;

  always_ff @(posedge i_clk) begin
    if (w_accept && i_wb_we && !w_outOfRange) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wb_sel[b]) r_mem[w_idx][8*b +: 8] <= i_wb_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lastWrValid <= 1'b0;
      r_lastWrIdx   <= '0;
    end else begin
      r_lastWrValid <= w_accept && i_wb_we;
      r_lastWrIdx   <= w_idx;
    end
  end

  // Dropping the bus cycle abandons everything still in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_wb_cyc) begin
      r_pipeValid <= '0;
    end else begin
      r_pipeValid[0] <= w_accept;
      for (int s = 1; s < LATENCY; s++) r_pipeValid[s] <= r_pipeValid[s-1];
    end
  end

  always_ff @(posedge i_clk) begin
    r_pipeErr[0]  <= w_outOfRange;
    r_pipeData[0] <= (!i_wb_we && !w_outOfRange) ? r_mem[w_idx] : 32'd0;
    for (int s = 1; s < LATENCY; s++) begin
      r_pipeErr[s]  <= r_pipeErr[s-1];
      r_pipeData[s] <= r_pipeData[s-1];
    end
  end

  assign w_respValid = r_pipeValid[LATENCY-1] && i_wb_cyc;
  assign o_wb_ack    = w_respValid && !r_pipeErr[LATENCY-1];
  assign o_wb_data   = o_wb_ack ? r_pipeData[LATENCY-1] : 32'd0;

`ifdef WB_SRAM_ERR_EN
  assign o_wb_err = w_respValid && r_pipeErr[LATENCY-1];
`else
  assign o_wb_err = 1'b0;
`endif

endmodule
